// File: rtl/byte_lane_sequencer.sv
// byte_lane_sequencer
// Breaks one word request covering byte lanes begin_offset..end_offset into a
// run of single-byte memory accesses, then returns one word response.
//
// Handshakes: every channel uses valid/ready. A request transfers on a rising
// edge where req_valid && req_ready. A response transfers on a rising edge
// where rsp_valid && rsp_ready. A byte access is offered while mem_en is high.
// It completes on a rising edge where mem_ack is high. Until then, its address,
// write enable and write byte stay unchanged.
module byte_lane_sequencer #(
    parameter int OFFSET_SIZE = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [OFFSET_SIZE-1:0] begin_offset,
    input  logic [OFFSET_SIZE-1:0] end_offset,
    input  logic [DATA_WIDTH-1:0]  req_wdata,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [7:0]             mem_wdata,
    input  logic [7:0]             mem_rdata,
    input  logic                   mem_ack,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_WIDTH-1:0]  rsp_rdata,
    output logic                   rsp_err
);

    localparam int BASE_W = ADDR_WIDTH - OFFSET_SIZE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   we_q, we_d;
    logic [BASE_W-1:0]      base_q, base_d;
    logic [OFFSET_SIZE-1:0] begin_q, begin_d;
    logic [OFFSET_SIZE-1:0] end_q, end_d;
    logic [OFFSET_SIZE-1:0] cur_q, cur_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic                   err_q, err_d;
    // Goes high on the first clock edge after reset. Until then, req_ready stays low.
    logic                   live_q, live_d;

    logic accept;
    logic last_lane;

    assign accept    = req_valid && req_ready;
    assign last_lane = (cur_q == end_q);

    // Next-state and datapath update for the request/issue/response sequence.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        base_d  = base_q;
        begin_d = begin_q;
        end_d   = end_q;
        cur_d   = cur_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        live_d  = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d    = req_we;
                    base_d  = req_addr[ADDR_WIDTH-1:OFFSET_SIZE];
                    begin_d = begin_offset;
                    end_d   = end_offset;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (begin_offset <= end_offset) begin
                        cur_d   = begin_offset;
                        state_d = ISSUE;
                    end else begin
                        // A reversed lane range is reported without touching memory.
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            ISSUE: begin
                if (mem_ack) begin
                    if (!we_q) begin
                        rdata_d[{cur_q, 3'b000} +: 8] = mem_rdata;
                    end
                    if (last_lane) begin
                        state_d = RESP;
                    end else begin
                        // The counter never passes end_q, so it cannot wrap.
                        cur_d = cur_q + 1'b1;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers. Reset clears them at once and abandons any transaction in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            base_q  <= '0;
            begin_q <= '0;
            end_q   <= '0;
            cur_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            base_q  <= base_d;
            begin_q <= begin_d;
            end_q   <= end_d;
            cur_q   <= cur_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            live_q  <= live_d;
        end
    end

    // Outputs depend only on registered state. Memory-side signals are zero unless an access is being offered.
    always_comb begin
        req_ready = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        rsp_valid = 1'b0;
        rsp_rdata = rdata_q;
        rsp_err   = err_q;

        unique case (state_q)
            IDLE: begin
                req_ready = live_q;
            end
            ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_addr  = {base_q, cur_q};
                mem_wdata = wdata_q[{cur_q, 3'b000} +: 8];
            end
            RESP: begin
                rsp_valid = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
